finn_axis_downsizer: RTL

FINN_AXIS_DOWNSIZER -- requirements
Module: finn_axis_downsizer

---
 rtl/finn_axis_downsizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/finn_axis_downsizer.sv
// AXI-Stream width downsizer: splits each IN_W = OUT_W*RATIO input word into RATIO
// output slices, with optional frame-based TLAST generation and a completed-frame counter.
module finn_axis_downsizer #(
   parameter int  OUT_W       = 8,
   parameter int  RATIO       = 5,
   parameter int  LSB_FIRST   = 1,
   parameter int  FRAME_BEATS = 0,
   localparam int IN_W        = OUT_W * RATIO
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [IN_W-1:0]  s_axis_0_tdata,
   input  logic             s_axis_0_tvalid,
   output logic             s_axis_0_tready,
   output logic [OUT_W-1:0] m_axis_0_tdata,
   output logic             m_axis_0_tvalid,
   input  logic             m_axis_0_tready,
   output logic             m_axis_0_tlast,
   output logic [15:0]      frame_cnt
);

   localparam int IDX_W = $clog2(RATIO);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t           state_reg, state_next;
   logic [IN_W-1:0]  word_reg, word_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             tag_reg;
   logic [15:0]      frame_cnt_reg;

   logic busy, last_slice, out_hs, in_hs;
   logic [IDX_W-1:0] sel;
   logic [OUT_W-1:0] slices [RATIO];

   assign busy       = (state_reg == EMIT);
   assign last_slice = (idx_reg == IDX_LAST);
   assign out_hs     = busy && m_axis_0_tready;
   // Accept a new word when idle, or when the final slice leaves this very cycle.
   assign s_axis_0_tready = !busy || (out_hs && last_slice);
   assign in_hs           = s_axis_0_tvalid && s_axis_0_tready;

   assign m_axis_0_tvalid = busy;
   assign m_axis_0_tlast  = busy && tag_reg && last_slice;
   assign frame_cnt       = frame_cnt_reg;

   for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slices[gi] = word_reg[gi*OUT_W +: OUT_W];
   end

   if (LSB_FIRST != 0) begin : g_lsb_first
      assign sel = idx_reg;
   end else begin : g_msb_first
      assign sel = IDX_LAST - idx_reg;
   end

   assign m_axis_0_tdata = slices[sel];

   always_comb begin
      state_next = state_reg;
      word_next  = word_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            if (in_hs) begin
               state_next = EMIT;
               word_next  = s_axis_0_tdata;
               idx_next   = '0;
            end
         end
         EMIT: begin
            if (out_hs) begin
               if (!last_slice) begin
                  idx_next = idx_reg + 1'b1;
               end else if (in_hs) begin
                  word_next = s_axis_0_tdata;
                  idx_next  = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_reg <= IDLE;
         word_reg  <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         word_reg  <= word_next;
         idx_reg   <= idx_next;
      end
   end

   if (FRAME_BEATS > 0) begin : g_frame
      localparam int FB_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
      localparam logic [FB_W-1:0] FB_LAST = FB_W'(FRAME_BEATS - 1);
      logic [FB_W-1:0] fbeat_reg;

      // The tag follows the word it was captured with, so it is updated on acceptance only.
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            fbeat_reg <= '0;
            tag_reg   <= 1'b0;
         end else if (in_hs) begin
            tag_reg   <= (fbeat_reg == FB_LAST);
            fbeat_reg <= (fbeat_reg == FB_LAST) ? '0 : fbeat_reg + 1'b1;
         end
      end
   end else begin : g_no_frame
      assign tag_reg = 1'b0;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         frame_cnt_reg <= '0;
      end else if (out_hs && m_axis_0_tlast) begin
         frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
   end

endmodule
